// File: rtl/main_mod_pkg.sv
// Shared definitions for the LFU/LRU superblock cache: address field layout,
// default geometry and the per-way tag entry.
package main_mod_pkg;

  localparam int ADDR_W  = 32;
  localparam int TAG_LSB = 12;
  localparam int TAG_W   = 20;
  localparam int SET_LSB = 8;
  localparam int BLK_LSB = 6;
  localparam int BLK_W   = 2;
  localparam int BLK_N   = 4;

  localparam int DEF_SETS  = 16;
  localparam int DEF_WAYS  = 4;
  localparam int DEF_CNT_W = 4;

  // LFU counter and LRU age live in separate arrays because their widths follow module parameters
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [BLK_N-1:0]  present;
  } way_t;

  function automatic logic [BLK_N-1:0] blk_onehot(input logic [BLK_W-1:0] blk);
    return BLK_N'(1) << blk;
  endfunction

endpackage

// File: rtl/main_mod_victim_select.sv
// Picks the way to overwrite in one set: first invalid way, otherwise the
// least-frequently-used way, breaking ties on the oldest LRU age then lowest index.
module victim_select
  import main_mod_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int AGE_W = 2,
  parameter int WAY_W = 2
) (
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS*CNT_W-1:0] lfu,
  input  logic [WAYS*AGE_W-1:0] age,
  output logic [WAY_W-1:0]      victim
);

  logic             found_invalid;
  logic [CNT_W-1:0] best_lfu;
  logic [AGE_W-1:0] best_age;

  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    best_lfu      = lfu[CNT_W-1:0];
    best_age      = age[AGE_W-1:0];
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found_invalid) begin
        found_invalid = 1'b1;
        victim        = WAY_W'(w);
      end
    end
    // Strict comparisons keep the lower index on a full tie
    if (!found_invalid) begin
      for (int w = 1; w < WAYS; w++) begin
        if ((lfu[w*CNT_W +: CNT_W] < best_lfu) ||
            ((lfu[w*CNT_W +: CNT_W] == best_lfu) && (age[w*AGE_W +: AGE_W] > best_age))) begin
          best_lfu = lfu[w*CNT_W +: CNT_W];
          best_age = age[w*AGE_W +: AGE_W];
          victim   = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/main_mod.sv
// Set-associative superblock cache model: one lookup/update per clock, with
// LFU-then-LRU replacement and running access/hit/allocation counters.
module main_mod
  import main_mod_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int WAYS  = DEF_WAYS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  output logic        hit,
  output logic        sb_miss,
  output logic [31:0] enter,
  output logic [31:0] access_count,
  output logic [31:0] hit_count
);

  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  way_t             ways  [SETS][WAYS];
  logic [CNT_W-1:0] lfu_q [SETS][WAYS];
  logic [AGE_W-1:0] age_q [SETS][WAYS];

  logic [TAG_W-1:0]      addr_tag;
  logic [SET_W-1:0]      set_idx;
  logic [BLK_W-1:0]      blk;
  logic                  unused_bits;
  logic [WAYS-1:0]       valid_vec;
  logic [WAYS*CNT_W-1:0] lfu_vec;
  logic [WAYS*AGE_W-1:0] age_vec;
  logic                  match;
  logic [WAY_W-1:0]      match_idx;
  logic [WAY_W-1:0]      victim;
  logic [WAY_W-1:0]      target;
  way_t                  target_entry;
  logic                  blk_hit;
  logic [AGE_W-1:0]      old_age;
  logic [CNT_W-1:0]      target_lfu;
  logic [CNT_W-1:0]      new_lfu;
  logic [BLK_N-1:0]      new_present;

  assign addr_tag    = address[TAG_LSB +: TAG_W];
  assign set_idx     = address[SET_LSB +: SET_W];
  assign blk         = address[BLK_LSB +: BLK_W];
  assign unused_bits = ^address[BLK_LSB-1:0];

  always_comb begin
    valid_vec = '0;
    lfu_vec   = '0;
    age_vec   = '0;
    match     = 1'b0;
    match_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w]                = ways[set_idx][w].valid;
      lfu_vec[w*CNT_W +: CNT_W]   = lfu_q[set_idx][w];
      age_vec[w*AGE_W +: AGE_W]   = age_q[set_idx][w];
      if (ways[set_idx][w].valid && (ways[set_idx][w].tag == addr_tag)) begin
        match     = 1'b1;
        match_idx = WAY_W'(w);
      end
    end
  end

  victim_select #(
    .WAYS  (WAYS),
    .CNT_W (CNT_W),
    .AGE_W (AGE_W),
    .WAY_W (WAY_W)
  ) u_victim (
    .valid  (valid_vec),
    .lfu    (lfu_vec),
    .age    (age_vec),
    .victim (victim)
  );

  // An empty way counts as oldest so that filling it ages every resident way
  assign target       = match ? match_idx : victim;
  assign target_entry = ways[set_idx][target];
  assign target_lfu   = lfu_q[set_idx][target];
  assign blk_hit      = match && target_entry.present[blk];
  assign old_age      = target_entry.valid ? age_q[set_idx][target] : AGE_MAX;
  assign new_lfu      = !match ? CNT_W'(1) :
                        (target_lfu == CNT_MAX) ? target_lfu : target_lfu + CNT_W'(1);
  assign new_present  = match ? (target_entry.present | blk_onehot(blk)) : blk_onehot(blk);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ways[s][w]  <= '0;
          lfu_q[s][w] <= '0;
          age_q[s][w] <= '0;
        end
      end
      hit          <= 1'b0;
      sb_miss      <= 1'b0;
      enter        <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      hit          <= blk_hit;
      sb_miss      <= !match;
      access_count <= access_count + 32'd1;
      if (blk_hit) hit_count <= hit_count + 32'd1;
      if (!match)  enter     <= enter + 32'd1;
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == target) begin
          ways[set_idx][w]  <= '{valid: 1'b1, tag: addr_tag, present: new_present};
          lfu_q[set_idx][w] <= new_lfu;
          age_q[set_idx][w] <= '0;
        end else if (ways[set_idx][w].valid && (age_q[set_idx][w] < old_age)) begin
          age_q[set_idx][w] <= age_q[set_idx][w] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_main_mod.sv
// Directed self-checking bench for main_mod: allocation, block fill, LFU and
// LRU replacement, counter saturation and asynchronous reset.
module tb_main_mod;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h0;
  logic        hit;
  logic        sb_miss;
  logic [31:0] enter;
  logic [31:0] access_count;
  logic [31:0] hit_count;

  int checks = 0;
  int failures = 0;

  logic        r_hit;
  logic        r_sb_miss;
  logic [31:0] r_enter;
  logic [31:0] r_access;
  logic [31:0] r_hits;

  main_mod dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .hit          (hit),
    .sb_miss      (sb_miss),
    .enter        (enter),
    .access_count (access_count),
    .hit_count    (hit_count)
  );

  always #5 clock = ~clock;

  // Starts and ends on a falling edge; captures outputs 1 time unit after the sampling edge
  task automatic access(input logic [31:0] a);
    address = a;
    @(posedge clock);
    #1;
    r_hit     = hit;
    r_sb_miss = sb_miss;
    r_enter   = enter;
    r_access  = access_count;
    r_hits    = hit_count;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %0d expected 0", hit); end
    checks++; if (sb_miss !== 1'b0) begin failures++; $display("FAIL reset_sb_miss: got %0d expected 0", sb_miss); end
    checks++; if (enter !== 32'd0) begin failures++; $display("FAIL reset_enter: got %0d expected 0", enter); end
    checks++; if (access_count !== 32'd0) begin failures++; $display("FAIL reset_access: got %0d expected 0", access_count); end
    checks++; if (hit_count !== 32'd0) begin failures++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_allocate();
    access(32'h0000_1000);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL alloc_hit: got %0d expected 0", r_hit); end
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL alloc_sb_miss: got %0d expected 1", r_sb_miss); end
    checks++; if (r_enter !== 32'd1) begin failures++; $display("FAIL alloc_enter: got %0d expected 1", r_enter); end
    checks++; if (r_access !== 32'd1) begin failures++; $display("FAIL alloc_access: got %0d expected 1", r_access); end
    access(32'h0000_1040);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL fill_hit: got %0d expected 0", r_hit); end
    checks++; if (r_sb_miss !== 1'b0) begin failures++; $display("FAIL fill_sb_miss: got %0d expected 0", r_sb_miss); end
    checks++; if (r_enter !== 32'd1) begin failures++; $display("FAIL fill_enter: got %0d expected 1", r_enter); end
    access(32'h0000_1040);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL rehit_hit: got %0d expected 1", r_hit); end
    checks++; if (r_hits !== 32'd1) begin failures++; $display("FAIL rehit_hit_count: got %0d expected 1", r_hits); end
    access(32'h0000_1100);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL other_set_sb_miss: got %0d expected 1", r_sb_miss); end
    checks++; if (r_enter !== 32'd2) begin failures++; $display("FAIL other_set_enter: got %0d expected 2", r_enter); end
    checks++; if (r_access !== 32'd4) begin failures++; $display("FAIL other_set_access: got %0d expected 4", r_access); end
  endtask

  task automatic test_lfu_victim();
    do_reset();
    for (int t = 1; t <= 4; t++) access(32'(t) << 12);
    for (int t = 2; t <= 4; t++) begin
      access(32'(t) << 12);
      checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL lfu_warm_hit tag %0d: got %0d expected 1", t, r_hit); end
    end
    access(32'h0000_5000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL lfu_new_sb_miss: got %0d expected 1", r_sb_miss); end
    checks++; if (r_enter !== 32'd5) begin failures++; $display("FAIL lfu_new_enter: got %0d expected 5", r_enter); end
    access(32'h0000_2000);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL lfu_kept_tag2: got %0d expected 1", r_hit); end
    access(32'h0000_1000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL lfu_evicted_tag1: got %0d expected 1", r_sb_miss); end
  endtask

  task automatic test_lru_victim();
    do_reset();
    for (int t = 1; t <= 4; t++) access(32'(t) << 12);
    access(32'h0000_5000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL lru_tag5_sb_miss: got %0d expected 1", r_sb_miss); end
    access(32'h0000_6000);
    checks++; if (r_enter !== 32'd6) begin failures++; $display("FAIL lru_tag6_enter: got %0d expected 6", r_enter); end
    access(32'h0000_5000);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL lru_kept_tag5: got %0d expected 1", r_hit); end
    access(32'h0000_2000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL lru_evicted_tag2: got %0d expected 1", r_sb_miss); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) access(32'h0000_1000);
    checks++; if (r_hits !== 32'd19) begin failures++; $display("FAIL sat_hit_count: got %0d expected 19", r_hits); end
    checks++; if (r_access !== 32'd20) begin failures++; $display("FAIL sat_access: got %0d expected 20", r_access); end
    for (int t = 2; t <= 4; t++)
      for (int i = 0; i < 5; i++) access(32'(t) << 12);
    access(32'h0000_5000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL sat_new_sb_miss: got %0d expected 1", r_sb_miss); end
    access(32'h0000_1000);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL sat_kept_hot_way: got %0d expected 1", r_hit); end
    access(32'h0000_2000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL sat_evicted_tag2: got %0d expected 1", r_sb_miss); end
  endtask

  task automatic test_async_reset();
    do_reset();
    access(32'h0000_7000);
    access(32'h0000_7000);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL pre_reset_hit: got %0d expected 1", r_hit); end
    reset = 1'b1;
    #2;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL async_hit: got %0d expected 0", hit); end
    checks++; if (sb_miss !== 1'b0) begin failures++; $display("FAIL async_sb_miss: got %0d expected 0", sb_miss); end
    checks++; if (enter !== 32'd0) begin failures++; $display("FAIL async_enter: got %0d expected 0", enter); end
    checks++; if (access_count !== 32'd0) begin failures++; $display("FAIL async_access: got %0d expected 0", access_count); end
    checks++; if (hit_count !== 32'd0) begin failures++; $display("FAIL async_hit_count: got %0d expected 0", hit_count); end
    @(negedge clock);
    reset = 1'b0;
    access(32'h0000_7000);
    checks++; if (r_sb_miss !== 1'b1) begin failures++; $display("FAIL post_reset_sb_miss: got %0d expected 1", r_sb_miss); end
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL post_reset_hit: got %0d expected 0", r_hit); end
    checks++; if (r_access !== 32'd1) begin failures++; $display("FAIL post_reset_access: got %0d expected 1", r_access); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_lfu_victim();
    test_lru_victim();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
